// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and constants for the matrix-multiply sequencer
//
// Purpose: sequencer state enum, default geometry and the accumulator width
// function used by matmul_seq_ctrl and matmul_mac.
package matmul_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam int DW_DEF = 4;
  localparam int N_DEF  = 2;

  // A dot product of N terms of two DW-bit values needs 2*DW + clog2(N) bits.
  function automatic int calc_accw(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - registered unsigned multiply-accumulate unit
//
// Purpose: acc <= first ? a*b : acc + a*b, updated only when en is high.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              perform one MAC step this cycle
//   first           load the product instead of accumulating
//   a, b [DW-1:0]   unsigned operands
//   acc [ACCW-1:0]  registered accumulator
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = calc_accw(DW_DEF, N_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            first,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] acc
);

  logic [ACCW-1:0] prod;

  assign prod = ACCW'(a) * ACCW'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= first ? prod : acc + prod;
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - serial-load N x N matrix-multiply sequencer
//
// Purpose: loads A then B row-major over a valid/ready stream, computes
// C = A*B with one MAC per cycle (i, j, k order), then streams C row-major.
// Optional build macro MATMUL_JOBCNT_EN adds the job_cnt output.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   clr                    synchronous abort of the current job
//   in_valid/in_ready      input handshake, in_data [DW-1:0]
//   out_valid/out_ready    output handshake, out_data [ACCW-1:0], out_last
//   busy                   high while computing or draining
//   job_cnt [7:0]          completed-job counter (MATMUL_JOBCNT_EN only)
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter  int DW   = DW_DEF,
  parameter  int N    = N_DEF,
  localparam int ACCW = calc_accw(DW, N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_data,
  output logic            out_last,
  output logic            busy
`ifdef MATMUL_JOBCNT_EN
  ,
  output logic [7:0]      job_cnt
`endif
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int CW = $clog2(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);
  localparam logic [CW-1:0] K_LAST   = CW'(N - 1);

  state_t state, state_nxt;

  // cnt is the load position in LOAD_A/LOAD_B and the read index in DRAIN.
  logic [IW-1:0] cnt;
  logic [CW-1:0] ci, cj, ck;
  logic [DW-1:0]   a_mem [NN];
  logic [DW-1:0]   b_mem [NN];
  logic [ACCW-1:0] c_mem [NN];

  // The MAC result for (i, j) is registered, so its C write lands one cycle
  // after the k = N-1 step; the final write falls in the first DRAIN cycle,
  // well before that entry is read out.
  logic            wr_pend;
  logic [IW-1:0]   wr_idx;

  logic [IW-1:0]   a_idx, b_idx;
  logic [ACCW-1:0] mac_acc;
  logic            cnt_last, mac_last;

  assign a_idx    = IW'(ci) * IW'(N) + IW'(ck);
  assign b_idx    = IW'(ck) * IW'(N) + IW'(cj);
  assign cnt_last = (cnt == IDX_LAST);
  assign mac_last = (ci == K_LAST) && (cj == K_LAST) && (ck == K_LAST);

  matmul_mac #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == COMPUTE),
    .first (ck == '0),
    .a     (a_mem[a_idx]),
    .b     (b_mem[b_idx]),
    .acc   (mac_acc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr overrides every transition
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = LOAD_A;
    end else begin
      case (state)
        LOAD_A:  if (in_valid && cnt_last) state_nxt = LOAD_B;
        LOAD_B:  if (in_valid && cnt_last) state_nxt = COMPUTE;
        COMPUTE: if (mac_last)             state_nxt = DRAIN;
        DRAIN:   if (out_ready && cnt_last) state_nxt = LOAD_A;
        default: state_nxt = LOAD_A;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      LOAD_A, LOAD_B: in_ready = 1'b1;
      COMPUTE:        busy = 1'b1;
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = cnt_last;
        out_data  = c_mem[cnt];
      end
      default: ;
    endcase
  end

  // Counters, operand storage and result storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ci      <= '0;
      cj      <= '0;
      ck      <= '0;
      wr_pend <= 1'b0;
      wr_idx  <= '0;
      for (int idx = 0; idx < NN; idx++) begin
        a_mem[idx] <= '0;
        b_mem[idx] <= '0;
        c_mem[idx] <= '0;
      end
    end else begin
      wr_pend <= 1'b0;
      if (wr_pend) begin
        c_mem[wr_idx] <= mac_acc;
      end
      if (clr) begin
        cnt <= '0;
        ci  <= '0;
        cj  <= '0;
        ck  <= '0;
      end else begin
        case (state)
          LOAD_A: begin
            if (in_valid) begin
              a_mem[cnt] <= in_data;
              cnt        <= cnt_last ? '0 : cnt + 1'b1;
            end
          end
          LOAD_B: begin
            if (in_valid) begin
              b_mem[cnt] <= in_data;
              cnt        <= cnt_last ? '0 : cnt + 1'b1;
            end
          end
          COMPUTE: begin
            wr_pend <= (ck == K_LAST);
            wr_idx  <= IW'(ci) * IW'(N) + IW'(cj);
            if (ck == K_LAST) begin
              ck <= '0;
              if (cj == K_LAST) begin
                cj <= '0;
                ci <= (ci == K_LAST) ? '0 : ci + 1'b1;
              end else begin
                cj <= cj + 1'b1;
              end
            end else begin
              ck <= ck + 1'b1;
            end
          end
          DRAIN: begin
            if (out_ready) begin
              cnt <= cnt_last ? '0 : cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MATMUL_JOBCNT_EN
  // Counts completed jobs; deliberately ignores clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_cnt <= 8'd0;
    end else if (out_valid && out_ready && out_last) begin
      job_cnt <= job_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - scoreboard testbench for matmul_seq_ctrl
module tb_matmul_seq_ctrl;

  localparam int DW   = 4;
  localparam int N    = 2;
  localparam int NN   = N * N;
  localparam int ACCW = 2 * DW + $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [ACCW-1:0] out_data;
  logic            out_last;
  logic            busy;
`ifdef MATMUL_JOBCNT_EN
  logic [7:0]      job_cnt;
`endif

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_in_cyc = 0;
  int first_out_cyc = 0;
  bit prev_ov = 1'b0;
  bit held_v = 1'b0;
  logic [ACCW-1:0] held_d;
  int rdy_mode = 0;
  int pidx = 0;
  int ja[NN];
  int jb[NN];

  matmul_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef MATMUL_JOBCNT_EN
    ,
    .job_cnt   (job_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // out_ready driver, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    pidx++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard, sampling on the falling edge
  always @(negedge clk) begin
    if (in_valid && in_ready && !clr) last_in_cyc = cyc;
    if (out_valid && !prev_ov) first_out_cyc = cyc;
    if (held_v && out_valid) check("stall_hold", out_data, held_d);
    held_v = 1'b0;
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{-1, 1'b0};
      check("out_data", out_data, e.data);
      check("out_last", out_last, e.last);
    end else if (out_valid) begin
      held_v = 1'b1;
      held_d = out_data;
    end
    prev_ov = out_valid;
  end

  task automatic push_job(input int a[NN], input int b[NN]);
    int s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += a[i*N+k] * b[k*N+j];
        exp_q.push_back('{s, (i == N-1) && (j == N-1)});
      end
    end
  endtask

  task automatic send(input int v, input int gap_pct);
    int w;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = DW'(v);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic load_job(input int a[NN], input int b[NN], input int gap_pct);
    for (int m = 0; m < 2 * NN; m++) send((m < NN) ? a[m] : b[m-NN], gap_pct);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !in_ready) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("job_done", exp_q.size(), 0);
  endtask

  task automatic run_job(input int a[NN], input int b[NN], input int gap_pct);
    push_job(a, b);
    load_job(a, b, gap_pct);
    wait_idle();
  endtask

  task automatic rand_job(input int gap_pct);
    for (int m = 0; m < NN; m++) begin
      ja[m] = $urandom_range(0, 15);
      jb[m] = $urandom_range(0, 15);
    end
    run_job(ja, jb, gap_pct);
  endtask

  // Loads a job, then aborts it with clr in the third COMPUTE cycle.
  task automatic abort_job();
    load_job(ja, jb, 0);
    check("busy_compute", busy, 1);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_in_ready", in_ready, 1);
    check("clr_busy", busy, 0);
    check("clr_out_valid", out_valid, 0);
  endtask

  initial begin
    int base;
    int w;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);

    // Basic job with in_valid held high, plus latency
    rdy_mode = 0;
    ja = '{1, 2, 3, 4};
    jb = '{5, 6, 7, 8};
    run_job(ja, jb, 0);
    check("latency", first_out_cyc - last_in_cyc, N*N*N + 1);

    // Max operand values
    ja = '{15, 15, 15, 15};
    jb = '{15, 15, 15, 15};
    run_job(ja, jb, 0);

    // Output backpressure 1,0,0,1 and gappy input
    rdy_mode = 1;
    pidx = 0;
    ja = '{1, 2, 3, 4};
    jb = '{5, 6, 7, 8};
    run_job(ja, jb, 50);

    // Random operands, random gaps and random out_ready
    rdy_mode = 2;
    for (int r = 0; r < 3; r++) rand_job(30);
    rdy_mode = 0;

    // clr during COMPUTE, then identity job
    ja = '{3, 1, 4, 1};
    jb = '{5, 9, 2, 6};
    abort_job();
    repeat (3) @(negedge clk);
    check("post_clr_out_valid", out_valid, 0);
    ja = '{1, 0, 0, 1};
    jb = '{9, 8, 7, 6};
    run_job(ja, jb, 0);

    // clr during LOAD_A with a same-cycle input element, which is discarded
    for (int m = 0; m < 3; m++) send(7, 0);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd15;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    ja = '{2, 3, 5, 7};
    jb = '{11, 13, 1, 4};
    run_job(ja, jb, 0);

    // Asynchronous reset mid-DRAIN after two outputs
    ja = '{6, 7, 8, 9};
    jb = '{1, 2, 3, 4};
    push_job(ja, jb);
    base = hs_cnt;
    load_job(ja, jb, 0);
    w = 0;
    while (hs_cnt < base + 2 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check("pre_rst_count", hs_cnt - base, 2);
    #2;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_job(0);

`ifdef MATMUL_JOBCNT_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("jc_reset", job_cnt, 0);
    for (int r = 0; r < 3; r++) rand_job(0);
    abort_job();
    check("jc_three", job_cnt, 3);
    for (int r = 0; r < 252; r++) rand_job(0);
    check("jc_255", job_cnt, 255);
    rand_job(0);
    check("jc_wrap", job_cnt, 0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
